// File: rtl/neuron_scheduler_if.sv
// rtl/neuron_scheduler_if.sv - scheduler-to-neuron datapath port bundle
// Scheduler side is master (operands out, results in); the neuron side is slave.
interface neuron_scheduler_if #(
   parameter int n_stage = 2
);
   localparam int W  = 2**n_stage;
   localparam int UW = n_stage + 2;

   logic [W-1:0]  nrn_w;
   logic [W-1:0]  nrn_x;
   logic [2:0]    nrn_shift;
   logic [UW-1:0] nrn_minus_teta;
   logic [UW-1:0] nrn_previus_u;
   logic          nrn_was_spike;
   logic [UW-1:0] nrn_u_out;
   logic          nrn_is_spike;

   modport master (
      output nrn_w, nrn_x, nrn_shift, nrn_minus_teta, nrn_previus_u, nrn_was_spike,
      input  nrn_u_out, nrn_is_spike
   );

   modport slave (
      input  nrn_w, nrn_x, nrn_shift, nrn_minus_teta, nrn_previus_u, nrn_was_spike,
      output nrn_u_out, nrn_is_spike
   );
endinterface

// File: rtl/neuron_scheduler.sv
// rtl/neuron_scheduler.sv - time-multiplexes one neuron datapath over N_NEURONS neurons
// Optional NEURON_SCHED_UREAD_EN adds a combinational potential read port (u_rd_addr/u_rd_data).
module neuron_scheduler #(
   parameter  int n_stage   = 2,
   parameter  int N_NEURONS = 4,
   localparam int W         = 2**n_stage,
   localparam int UW        = n_stage + 2,
   localparam int AW        = $clog2(N_NEURONS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_we,
   input  logic [AW-1:0]        cfg_addr,
   input  logic [W-1:0]         cfg_wdata,
   input  logic                 clr,
   input  logic                 start,
   input  logic [W-1:0]         x_in,
   input  logic [2:0]           shift,
   input  logic [UW-1:0]        minus_teta,
   output logic                 busy,
   output logic                 done,
   output logic [N_NEURONS-1:0] spikes_out,
`ifdef NEURON_SCHED_UREAD_EN
   input  logic [AW-1:0]        u_rd_addr,
   output logic [UW-1:0]        u_rd_data,
`endif
   neuron_scheduler_if.master   nrn
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [AW-1:0]         idx_q, idx_d;
   logic [W-1:0]          x_q, x_d;
   logic [2:0]            shift_q, shift_d;
   logic [UW-1:0]         mteta_q, mteta_d;
   logic [W-1:0]          w_q [N_NEURONS];
   logic [W-1:0]          w_d [N_NEURONS];
   logic [UW-1:0]         u_q [N_NEURONS];
   logic [UW-1:0]         u_d [N_NEURONS];
   logic [N_NEURONS-1:0]  sp_q, sp_d;
   logic [N_NEURONS-1:0]  spikes_q, spikes_d;
   logic                  run;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         x_q      <= '0;
         shift_q  <= '0;
         mteta_q  <= '0;
         sp_q     <= '0;
         spikes_q <= '0;
         for (int i = 0; i < N_NEURONS; i++) begin
            w_q[i] <= '0;
            u_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         x_q      <= x_d;
         shift_q  <= shift_d;
         mteta_q  <= mteta_d;
         sp_q     <= sp_d;
         spikes_q <= spikes_d;
         w_q      <= w_d;
         u_q      <= u_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      x_d      = x_q;
      shift_d  = shift_q;
      mteta_d  = mteta_q;
      w_d      = w_q;
      u_d      = u_q;
      sp_d     = sp_q;
      spikes_d = spikes_q;
      case (state_q)
         S_IDLE: begin
            // A weight written alongside start is already in place for the first RUN read.
            if (cfg_we) w_d[cfg_addr] = cfg_wdata;
            if (clr) begin
               for (int i = 0; i < N_NEURONS; i++) u_d[i] = '0;
               sp_d = '0;
            end else if (start) begin
               state_d = S_RUN;
               idx_d   = '0;
               x_d     = x_in;
               shift_d = shift;
               mteta_d = minus_teta;
            end
         end
         S_RUN: begin
            u_d[idx_q]  = nrn.nrn_u_out;
            sp_d[idx_q] = nrn.nrn_is_spike;
            idx_d       = idx_q + AW'(1);
            if (idx_q == AW'(N_NEURONS - 1)) state_d = S_DONE;
         end
         S_DONE: begin
            spikes_d = sp_q;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign run        = (state_q == S_RUN);
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign spikes_out = spikes_q;

   assign nrn.nrn_w          = run ? w_q[idx_q] : '0;
   assign nrn.nrn_x          = run ? x_q        : '0;
   assign nrn.nrn_shift      = run ? shift_q    : '0;
   assign nrn.nrn_minus_teta = run ? mteta_q    : '0;
   assign nrn.nrn_previus_u  = run ? u_q[idx_q] : '0;
   assign nrn.nrn_was_spike  = run ? sp_q[idx_q] : 1'b0;

`ifdef NEURON_SCHED_UREAD_EN
   assign u_rd_data = u_q[u_rd_addr];
`endif

endmodule

// File: tb/tb_neuron_scheduler.sv
// tb/tb_neuron_scheduler.sv - self-checking bench with stub datapath and per-neuron reference model
module tb_neuron_scheduler;
   localparam int NS = 2;
   localparam int N  = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_we;
   logic [1:0] cfg_addr;
   logic [3:0] cfg_wdata;
   logic       clr;
   logic       start;
   logic [3:0] x_in;
   logic [2:0] shift;
   logic [3:0] minus_teta;
   logic       busy;
   logic       done;
   logic [3:0] spikes_out;
`ifdef NEURON_SCHED_UREAD_EN
   logic [1:0] u_rd_addr;
   logic [3:0] u_rd_data;
`endif

   neuron_scheduler_if #(.n_stage(NS)) nrn_if ();

   assign nrn_if.nrn_u_out    = nrn_if.nrn_previus_u + 4'd1;
   assign nrn_if.nrn_is_spike = (nrn_if.nrn_u_out == 4'd3);

   neuron_scheduler #(.n_stage(NS), .N_NEURONS(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .clr        (clr),
      .start      (start),
      .x_in       (x_in),
      .shift      (shift),
      .minus_teta (minus_teta),
      .busy       (busy),
      .done       (done),
      .spikes_out (spikes_out),
`ifdef NEURON_SCHED_UREAD_EN
      .u_rd_addr  (u_rd_addr),
      .u_rd_data  (u_rd_data),
`endif
      .nrn        (nrn_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [3:0] mw [N];
   logic [3:0] mu [N];
   logic       msp [N];
   logic [3:0] mspikes;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mw[i]  = 4'd0;
         mu[i]  = 4'd0;
         msp[i] = 1'b0;
      end
      mspikes = 4'd0;
   endtask

   task automatic check_u();
`ifdef NEURON_SCHED_UREAD_EN
      for (int i = 0; i < N; i++) begin
         u_rd_addr = 2'(i);
         #1;
         chk($sformatf("u_rd[%0d]", i), 32'(u_rd_data), 32'(mu[i]));
      end
`endif
   endtask

   task automatic write_w(input int a, input logic [3:0] d);
      cfg_we = 1'b1; cfg_addr = 2'(a); cfg_wdata = d;
      mw[a] = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // Called at a negedge in an IDLE cycle; returns at a negedge in the following IDLE cycle.
   task automatic step(input logic [3:0] x, input logic [2:0] sh, input logic [3:0] mt,
                       input bit wr, input bit inject, input int abort_at);
      logic [3:0] nu;
      logic [3:0] d;
      int a;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_nrn_w", 32'(nrn_if.nrn_w), 32'd0);
      chk("idle_nrn_x", 32'(nrn_if.nrn_x), 32'd0);
      chk("idle_prev_u", 32'(nrn_if.nrn_previus_u), 32'd0);
      start = 1'b1; x_in = x; shift = sh; minus_teta = mt;
      if (wr) begin
         a = $urandom_range(0, N - 1);
         d = 4'($urandom);
         cfg_we = 1'b1; cfg_addr = 2'(a); cfg_wdata = d;
         mw[a] = d;
      end
      @(negedge clk);
      start = 1'b0; cfg_we = 1'b0;
      x_in = 4'($urandom); shift = 3'($urandom); minus_teta = 4'($urandom);
      for (int k = 0; k < N; k++) begin
         chk($sformatf("run%0d_busy", k), 32'(busy), 32'd1);
         chk($sformatf("run%0d_done", k), 32'(done), 32'd0);
         chk($sformatf("run%0d_w", k), 32'(nrn_if.nrn_w), 32'(mw[k]));
         chk($sformatf("run%0d_prev_u", k), 32'(nrn_if.nrn_previus_u), 32'(mu[k]));
         chk($sformatf("run%0d_was_spike", k), 32'(nrn_if.nrn_was_spike), 32'(msp[k]));
         chk($sformatf("run%0d_x", k), 32'(nrn_if.nrn_x), 32'(x));
         chk($sformatf("run%0d_shift", k), 32'(nrn_if.nrn_shift), 32'(sh));
         chk($sformatf("run%0d_mteta", k), 32'(nrn_if.nrn_minus_teta), 32'(mt));
         if (k == abort_at) begin
            rst = 1'b1;
            #1;
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_done", 32'(done), 32'd0);
            chk("abort_spikes", 32'(spikes_out), 32'd0);
            model_reset();
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            return;
         end
         nu = mu[k] + 4'd1;
         mu[k] = nu;
         msp[k] = (nu == 4'd3);
         if (inject && k == 1) start = 1'b1;
         if (inject && k == 2) begin
            start = 1'b0; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 4'hF;
         end
         @(negedge clk);
         if (inject && k == 2) cfg_we = 1'b0;
      end
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd1);
      chk("done_nrn_w", 32'(nrn_if.nrn_w), 32'd0);
      chk("done_spikes_old", 32'(spikes_out), 32'(mspikes));
      mspikes = {msp[3], msp[2], msp[1], msp[0]};
      @(negedge clk);
      chk("post_done", 32'(done), 32'd0);
      chk("post_busy", 32'(busy), 32'd0);
      chk("spikes_out", 32'(spikes_out), 32'(mspikes));
      if (inject) begin
         @(negedge clk);
         chk("no_queued_busy", 32'(busy), 32'd0);
         chk("no_queued_done", 32'(done), 32'd0);
      end
   endtask

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; clr = 1'b0;
      start = 1'b0; x_in = '0; shift = '0; minus_teta = '0;
`ifdef NEURON_SCHED_UREAD_EN
      u_rd_addr = '0;
`endif
      model_reset();
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_spikes", 32'(spikes_out), 32'd0);
      chk("rst_nrn_x", 32'(nrn_if.nrn_x), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // first timestep with fixed parameters
      step(4'b1010, 3'd3, 4'b1101, 1'b0, 1'b0, -1);
      check_u();

      // second and third timesteps reach the spike; fourth sees was_spike everywhere
      step(4'($urandom), 3'($urandom), 4'($urandom), 1'b0, 1'b0, -1);
      step(4'($urandom), 3'($urandom), 4'($urandom), 1'b0, 1'b0, -1);
      chk("third_spikes", 32'(spikes_out), 32'hF);
      step(4'($urandom), 3'($urandom), 4'($urandom), 1'b0, 1'b0, -1);

      // distinct weights appear in index order
      write_w(0, 4'h1);
      write_w(1, 4'h2);
      write_w(2, 4'h4);
      write_w(3, 4'h8);
      step(4'($urandom), 3'($urandom), 4'($urandom), 1'b0, 1'b0, -1);

      // start and cfg_we during RUN are dropped; weight 0 keeps 4'h1
      step(4'($urandom), 3'($urandom), 4'($urandom), 1'b0, 1'b1, -1);
      step(4'($urandom), 3'($urandom), 4'($urandom), 1'b1, 1'b0, -1);

      // reset in RUN cycle 3 aborts and clears everything
      step(4'($urandom), 3'($urandom), 4'($urandom), 1'b0, 1'b0, 2);
      step(4'($urandom), 3'($urandom), 4'($urandom), 1'b1, 1'b0, -1);
      step(4'($urandom), 3'($urandom), 4'($urandom), 1'b0, 1'b0, -1);

      // clr beats start in the same IDLE cycle
      clr = 1'b1; start = 1'b1;
      @(negedge clk);
      clr = 1'b0; start = 1'b0;
      chk("clr_no_run_busy", 32'(busy), 32'd0);
      chk("clr_no_run_done", 32'(done), 32'd0);
      for (int i = 0; i < N; i++) begin
         mu[i] = 4'd0;
         msp[i] = 1'b0;
      end
      check_u();
      @(negedge clk);
      chk("clr_still_idle", 32'(busy), 32'd0);

      for (int r = 0; r < 6; r++)
         step(4'($urandom), 3'($urandom), 4'($urandom), 1'($urandom), 1'b0, -1);
      check_u();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/neuron_scheduler.md
# neuron_scheduler

- Time-multiplexes one combinational `neuron` datapath across `N_NEURONS` logical neurons.
- Holds per-neuron weights, membrane potentials and last-spike flags.
- On each `start` it runs one timestep: it sequences every neuron through the datapath, one per clock, and writes the results back.
- Sits between the host/config logic and the `neuron` instance, which it drives through its `nrn_*` ports.

## Interface
Parameters:
- `n_stage`, default 2: datapath stage count. Weight/input width is `W = 2**n_stage`. Potential width is `UW = n_stage+2`.
- `N_NEURONS`, default 4: number of logical neurons, power of two, at least 2. Index width is `AW = log2(N_NEURONS)`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_we`  in  1  weight write strobe. Honoured in IDLE only.
- `cfg_addr`  in  AW  neuron index for the weight write.
- `cfg_wdata`  in  W  weight vector for the weight write.
- `clr`  in  1  zeroes all potentials and spike flags. Honoured in IDLE only.
- `start`  in  1  begin a timestep. Honoured in IDLE only.
- `x_in`  in  W  input spike vector, sampled with `start`.
- `shift`  in  3  decay shift, sampled with `start`.
- `minus_teta`  in  UW  negated threshold, sampled with `start`.
- `busy`  out  1  high while a timestep is in progress.
- `done`  out  1  one-cycle pulse when a timestep completes.
- `spikes_out`  out  N_NEURONS  spike vector from the last completed timestep.
- `nrn_w`  out  W  weight of the neuron currently scheduled.
- `nrn_x`  out  W  latched input vector.
- `nrn_shift`  out  3  latched decay shift.
- `nrn_minus_teta`  out  UW  latched negated threshold.
- `nrn_previus_u`  out  UW  stored potential of the current neuron.
- `nrn_was_spike`  out  1  stored spike flag of the current neuron.
- `nrn_u_out`  in  UW  datapath result: new potential.
- `nrn_is_spike`  in  1  datapath result: spike.

## Operation
States:
- IDLE. `start` moves to RUN. On the same edge it latches `x_in`, `shift` and `minus_teta`, and sets `idx = 0`.
- RUN. Each cycle the `nrn_*` outputs present neuron `idx`. On the edge:
  - `u[idx] <= nrn_u_out`
  - `sp[idx] <= nrn_is_spike`
  - `idx` increments.
  - After `idx = N_NEURONS-1`, move to DONE.
- DONE. One cycle: `done = 1` and `spikes_out <= sp`. Then return to IDLE.

Datapath presentation rules:
- `nrn_w`, `nrn_previus_u` and `nrn_was_spike` are combinational reads of entry `idx`.
- The latched parameters drive the datapath throughout RUN.
- Outside RUN, all `nrn_*` outputs are driven 0.

Storage and arithmetic:
- Potentials are stored unmodified, UW-bit two's complement. Saturation and reset-on-spike belong to the datapath; the scheduler only feeds `was_spike` back.

Boundary rules:
- `start` in RUN or DONE is ignored. It is not queued.
- `cfg_we` or `clr` outside IDLE is dropped.
- In IDLE, `clr` and `start` in the same cycle: `clr` wins and `start` is ignored.
- `cfg_we` and `start` in the same IDLE cycle: the write takes effect. The timestep uses the new weight.
- `idx` wraps to 0 on leaving RUN.
- `rst` mid-RUN aborts the timestep. Partially written potentials are cleared with the rest.

## Timing
- Reset values:
  - state IDLE, `idx` 0
  - all weights, potentials and spike flags 0
  - latched parameters 0
  - `busy` 0, `done` 0, `spikes_out` 0
- `start` sampled at edge t:
  - RUN occupies cycles t+1 .. t+N_NEURONS.
  - `done` is high in cycle t+N_NEURONS+1.
  - `spikes_out` updates on the edge ending that cycle.
- `busy` is high from cycle t+1 through the DONE cycle inclusive.
- Minimum `start`-to-`start` spacing: N_NEURONS+2 cycles.
- Weight writes and `clr` take effect on the edge they are sampled. They are visible the next cycle.

## Configuration
- `NEURON_SCHED_UREAD_EN` defined:
  - Adds input port `u_rd_addr` (AW bits).
  - Adds output port `u_rd_data` (UW bits), a combinational read of `u[u_rd_addr]`.
  - The read is valid in any state.
- Not defined: both ports are absent and the potentials are not observable externally.

## Test plan
All scenarios use `n_stage = 2` and `N_NEURONS = 4`. The bench replaces the datapath with a stub: `nrn_u_out = nrn_previus_u + 1` and `nrn_is_spike = (nrn_u_out == 3)`.

1. Reset, then `start` with `x_in = 4'b1010`, `shift = 3`, `minus_teta = 4'b1101`:
   - `busy` is high cycles 1-5 and `done` pulses in cycle 5.
   - `nrn_x`, `nrn_shift` and `nrn_minus_teta` hold the latched values through RUN.
   - All potentials read 1.
2. Three consecutive timesteps: `spikes_out = 4'b0000`, `4'b0000`, then `4'b1111` after the third. The `nrn_was_spike` seen in the fourth timestep is 1 for every index.
3. Write weights `4'h1`, `4'h2`, `4'h4`, `4'h8` to indices 0-3, then `start`: `nrn_w` in RUN cycles 1-4 reads `1`, `2`, `4`, `8` in order.
4. `start` asserted again in RUN cycle 2, and `cfg_we` to index 0 with `4'hF` in RUN cycle 3:
   - Both are ignored: a single `done` only, and weight 0 keeps its old value.
5. `rst` asserted in RUN cycle 3:
   - `busy`, `done` and `spikes_out` go to 0 immediately.
   - A following timestep sees `nrn_previus_u = 0` for all indices.
6. `clr` and `start` asserted together in IDLE after two timesteps:
   - No run starts and all potentials read 0.
   - With `NEURON_SCHED_UREAD_EN` defined, `u_rd_data = 0` for `u_rd_addr` 0-3.
